datapath_unit: RTL and testbench
================================

# datapath_unit

Datapath responder for the multiply-by-repeated-addition control unit. It contains a 16 × 8-bit register file, an input mux, a 4-function ALU and an output mux. It executes the per-cycle micro-commands the control unit issues (`InsSel`, `InMuxAdd`, `OutMuxAdd`, `RegAdd`, `we`, `CUconst`) and returns the `CO`/`Z` flags the control unit branches on. It sits directly below the control unit and exposes the final product on `Result`.

## Interface
- `W`, 8: datapath word width.
- `NREG`, 16: register-file depth; address width is fixed at 4.

- `clk`, input, 1: single clock; everything updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `InA`, input, W: external operand A.
- `InB`, input, W: external operand B.
- `CUconst`, input, W: constant from the control unit (0xFF is used as −1).
- `InsSel`, input, 2: ALU function select.
- `InMuxAdd`, input, 3: write-data source select.
- `OutMuxAdd`, input, 4: read address for `RegOut`.
- `RegAdd`, input, 4: write address.
- `we`, input, 1: register-file write enable.
- `RegOut`, output, W: Reg[`OutMuxAdd`], combinational read.
- `ALUout`, output, W: ALU result, combinational.
- `CO`, output, 1: ALU carry out, combinational.
- `Z`, output, 1: high when `ALUout` == 0, combinational.
- `Result`, output, W: registered copy of R0.
- `ResultValid`, output, 1: one-cycle pulse after R0 is written.

## Operation
- Input mux (`InMuxAdd`) selects the write data:
  - 0: `InA`
  - 1: `InB`
  - 2: `CUconst`
  - 3: `ALUout`
  - 4: `RegOut`
  - 5–7: 0x00
- Write rule: if `we` is high at a rising edge, Reg[`RegAdd`] takes the mux value; all other registers hold.
- There are no hard-wired registers; R0 is writable like any other register.
- ALU operands are fixed: operand X = R1, operand Y = R2. Functions by `InsSel`:
  - 0: X & Y, `CO` = 0
  - 1: X | Y, `CO` = 0
  - 2: X + Y, `CO` = bit W of the (W+1)-bit sum; the result wraps modulo 2^W
  - 3: X ^ Y, `CO` = 0
- `Z` = (`ALUout` == 0) for every function.
- Decrement is performed as X + 0xFF with `InsSel`=2. It yields `CO`=1 for X ≥ 1, and `CO`=0 with `ALUout`=0xFF for X = 0.
- Read path: `RegOut` is Reg[`OutMuxAdd`], with no write-to-read bypass.
- `Result` and `ResultValid`:
  - When `we`=1 and `RegAdd`=0, at that edge `Result` takes the value being written and `ResultValid` is set to 1.
  - At every other edge `ResultValid` is set to 0 and `Result` holds.
- The block has no internal state machine; it is a pure responder. Sequencing is owned entirely by the control unit.

## Timing
- Reset (synchronous, `reset`=1 at a rising edge):
  - All 16 registers become 0x00, `Result` becomes 0x00 and `ResultValid` becomes 0.
  - With all-zero registers, `ALUout` = 0, `Z` = 1, `CO` = 0 and `RegOut` = 0x00.
- Reset has priority over `we`. A write presented in a reset cycle is discarded.
- Reset asserted mid-sequence clears everything at that edge. There is no partial or retained state.
- Write latency:
  - The data is visible on `RegOut` (when addressed) from the cycle after the write edge.
  - Writing R1 or R2 changes `ALUout`, `CO` and `Z` in the cycle after the edge.
- Same-cycle read and write at the same address: `RegOut` shows the old value during that cycle and the new value afterwards.
- `ALUout` loop-back: `InMuxAdd`=3 with `RegAdd`=1 or 2 writes the current (pre-edge) ALU result. There is no combinational loop, because the operands are registered.
- `ResultValid` rises in the cycle after the R0 write edge and lasts exactly one cycle per write. Back-to-back R0 writes hold it high for consecutive cycles.
- `we` low: no register, `Result` or `ResultValid` change apart from `ResultValid` returning to 0.
- Address rule: all 16 addresses are valid and wrap-free, so there are no out-of-range accesses.

## Test plan
- **Reset:** drive junk into every register, then assert `reset` for 1 cycle with `we`=1. Required: every register reads 0x00 via `OutMuxAdd` 0–15, `Z`=1, `CO`=0, `Result`=0, `ResultValid`=0.
- **Load and read:** `InA`=0x05 → R3, `InB`=0x03 → R4, `CUconst`=0xFF → R2. Required: `RegOut`=0x05, 0x03 and 0xFF for `OutMuxAdd`=3, 4 and 2, each one cycle after its write. For any `InMuxAdd`=5 write, the target register reads 0x00.
- **Decrement flags:**
  - R1=0x01, R2=0xFF, `InsSel`=2 → `ALUout`=0x00, `Z`=1, `CO`=1.
  - R1=0x00 → `ALUout`=0xFF, `Z`=0, `CO`=0.
  - R1=0x80, R2=0x80 → `ALUout`=0x00, `CO`=1, `Z`=1.
- **Logic ops:** R1=0xF0, R2=0x3C. Required:
  - `InsSel` 0/1/3 gives 0x30/0xFC/0xCC, each with `CO`=0.
  - R2=0x0F with `InsSel`=0 gives `Z`=1.
- **Full multiply sequence:** the control unit plus this block with `InA`=5, `InB`=3. Required: `Result`=15 (0x0F) with a single `ResultValid` pulse coincident with `Busy` falling. Repeat with `InB`=0 and `InA`=0 and check `Result` against the control unit's defined outcome.
- **Hazards:**
  - Write R7=0xAA while `OutMuxAdd`=7. Required: old value in the write cycle, 0xAA in the next cycle.
  - Two consecutive writes to R0. Required: `ResultValid` high for exactly 2 cycles.
  - Assert reset in the middle of a write. Required: the write is lost.

Source files
------------

// File: rtl/datapath_unit.sv
// Datapath for the repeated-addition multiplier: 16x8 register file, write-data mux,
// 4-function ALU on fixed operands R1/R2, and a registered copy of R0 with a valid pulse.
module datapath_unit #(
  parameter int W    = 8,
  parameter int NREG = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] InA,
  input  logic [W-1:0] InB,
  input  logic [W-1:0] CUconst,
  input  logic [1:0]   InsSel,
  input  logic [2:0]   InMuxAdd,
  input  logic [3:0]   OutMuxAdd,
  input  logic [3:0]   RegAdd,
  input  logic         we,
  output logic [W-1:0] RegOut,
  output logic [W-1:0] ALUout,
  output logic         CO,
  output logic         Z,
  output logic [W-1:0] Result,
  output logic         ResultValid
);

  typedef enum logic [1:0] {
    ALU_AND = 2'd0,
    ALU_OR  = 2'd1,
    ALU_ADD = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  logic [W-1:0] regs_q [NREG];
  logic [W-1:0] regs_d [NREG];
  logic [W-1:0] result_q, result_d;
  logic         result_valid_q, result_valid_d;

  logic [W-1:0] op_x, op_y;
  logic [W:0]   sum;
  logic [W-1:0] alu_res;
  logic         alu_co;
  logic [W-1:0] wr_data;

  assign op_x   = regs_q[1];
  assign op_y   = regs_q[2];
  assign RegOut = regs_q[OutMuxAdd];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no case path can infer a latch.
    alu_res = '0;
    alu_co  = 1'b0;
    sum     = {1'b0, op_x} + {1'b0, op_y};
    case (alu_op_e'(InsSel))
      ALU_AND: alu_res = op_x & op_y;
      ALU_OR:  alu_res = op_x | op_y;
      ALU_ADD: begin
        alu_res = sum[W-1:0];
        alu_co  = sum[W];
      end
      ALU_XOR: alu_res = op_x ^ op_y;
      default: alu_res = '0;
    endcase
  end

  assign ALUout = alu_res;
  assign CO     = alu_co;
  assign Z      = (alu_res == '0);

  always_comb begin
    wr_data = '0;
    case (InMuxAdd)
      3'd0:    wr_data = InA;
      3'd1:    wr_data = InB;
      3'd2:    wr_data = CUconst;
      3'd3:    wr_data = alu_res;
      3'd4:    wr_data = RegOut;
      default: wr_data = '0;
    endcase
  end

  // Result mirrors every R0 write; the valid flag only ever lasts one cycle per write.
  always_comb begin
    regs_d         = regs_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    if (we) begin
      regs_d[RegAdd] = wr_data;
      if (RegAdd == 4'd0) begin
        result_d       = wr_data;
        result_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file is cleared on reset because the flags the control unit
      // branches on right after reset are defined from all-zero registers.
      regs_q         <= '{default: '0};
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every flop sample pre-edge values, which is what
      // lets an ALUout write-back into R1/R2 use the old operands.
      regs_q         <= regs_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign Result      = result_q;
  assign ResultValid = result_valid_q;

endmodule

// File: tb/tb_datapath_unit.sv
// Directed bench for datapath_unit: reset, loads, ALU flags, hazards and a multiply
// sequence driven by a small in-bench stand-in for the control unit.
module tb_datapath_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] InA, InB, CUconst;
  logic [1:0]   InsSel;
  logic [2:0]   InMuxAdd;
  logic [3:0]   OutMuxAdd, RegAdd;
  logic         we;
  logic [W-1:0] RegOut, ALUout, Result;
  logic         CO, Z, ResultValid;

  int total = 0;
  int bad   = 0;

  logic rv_clr = 1'b0;
  int   rv_cnt = 0;

  datapath_unit #(.W(W), .NREG(16)) dut (
    .clk(clk), .reset(reset), .InA(InA), .InB(InB), .CUconst(CUconst),
    .InsSel(InsSel), .InMuxAdd(InMuxAdd), .OutMuxAdd(OutMuxAdd), .RegAdd(RegAdd),
    .we(we), .RegOut(RegOut), .ALUout(ALUout), .CO(CO), .Z(Z),
    .Result(Result), .ResultValid(ResultValid)
  );

  always #5 clk = ~clk;

  // Counts ResultValid cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (rv_clr) rv_cnt <= 0;
    else if (ResultValid) rv_cnt <= rv_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and checks happen there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [2:0] src);
    we       = 1'b1;
    RegAdd   = addr;
    InMuxAdd = src;
    step();
    we       = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] addr, input logic [W-1:0] exp);
    OutMuxAdd = addr;
    #1;
    check(tag, RegOut, exp);
  endtask

  task automatic alu(input string tag, input logic [1:0] fn, input logic [W-1:0] exp_out,
                     input logic exp_co, input logic exp_z);
    InsSel = fn;
    #1;
    check({tag, "_out"}, ALUout, exp_out);
    check({tag, "_co"}, CO, exp_co);
    check({tag, "_z"}, Z, exp_z);
  endtask

  // Stand-in control unit: R3 accumulates, R4 counts down via R1 + 0xFF, R0 gets the product.
  task automatic multiply(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
    logic done;
    done   = 1'b0;
    InA    = a;
    InB    = b;
    rv_clr = 1'b1;
    wr(4'd3, 3'd5);
    rv_clr = 1'b0;
    wr(4'd4, 3'd1);
    for (int it = 0; it < 300; it++) begin
      OutMuxAdd = 4'd4;
      wr(4'd1, 3'd4);
      CUconst = 8'hFF;
      wr(4'd2, 3'd2);
      InsSel = 2'd2;
      #1;
      if (!CO) begin
        done = 1'b1;
        break;
      end
      wr(4'd4, 3'd3);
      OutMuxAdd = 4'd3;
      wr(4'd1, 3'd4);
      wr(4'd2, 3'd0);
      wr(4'd3, 3'd3);
    end
    check("mul_terminated", done, 1'b1);
    OutMuxAdd = 4'd3;
    wr(4'd0, 3'd4);
    check("mul_result", Result, exp);
    check("mul_valid_hi", ResultValid, 1'b1);
    step();
    check("mul_valid_lo", ResultValid, 1'b0);
    check("mul_valid_pulses", rv_cnt[15:0], 16'd1);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; InA = '0; InB = '0; CUconst = '0;
    InsSel = 2'd0; InMuxAdd = 3'd0; OutMuxAdd = 4'd0; RegAdd = 4'd0;
    step();
    step();
    reset = 1'b0;

    // Reset: junk everywhere, then reset with a write pending.
    for (int i = 0; i < 16; i++) begin
      InA = 8'(i * 17 + 3);
      wr(4'(i), 3'd0);
    end
    reset = 1'b1; we = 1'b1; RegAdd = 4'd0; InMuxAdd = 3'd0; InA = 8'h77;
    step();
    reset = 1'b0; we = 1'b0;
    for (int i = 0; i < 16; i++) rd($sformatf("reset_r%0d", i), 4'(i), 8'h00);
    alu("reset_alu", 2'd2, 8'h00, 1'b0, 1'b1);
    check("reset_result", Result, 8'h00);
    check("reset_valid", ResultValid, 1'b0);

    // Load through each mux source.
    InA = 8'h05; wr(4'd3, 3'd0); rd("load_ina", 4'd3, 8'h05);
    InB = 8'h03; wr(4'd4, 3'd1); rd("load_inb", 4'd4, 8'h03);
    CUconst = 8'hFF; wr(4'd2, 3'd2); rd("load_const", 4'd2, 8'hFF);
    InA = 8'h5A; wr(4'd5, 3'd0); wr(4'd5, 3'd5); rd("load_zero_src", 4'd5, 8'h00);
    OutMuxAdd = 4'd3; wr(4'd6, 3'd4); rd("load_regout_src", 4'd6, 8'h05);

    // Decrement flags.
    InA = 8'h01; wr(4'd1, 3'd0); alu("dec_one", 2'd2, 8'h00, 1'b1, 1'b1);
    InA = 8'h00; wr(4'd1, 3'd0); alu("dec_zero", 2'd2, 8'hFF, 1'b0, 1'b0);
    InA = 8'h80; wr(4'd1, 3'd0); wr(4'd2, 3'd0); alu("add_wrap", 2'd2, 8'h00, 1'b1, 1'b1);

    // Logic ops.
    InA = 8'hF0; wr(4'd1, 3'd0);
    InA = 8'h3C; wr(4'd2, 3'd0);
    alu("and", 2'd0, 8'h30, 1'b0, 1'b0);
    alu("or",  2'd1, 8'hFC, 1'b0, 1'b0);
    alu("xor", 2'd3, 8'hCC, 1'b0, 1'b0);
    InA = 8'h0F; wr(4'd2, 3'd0);
    alu("and_zero", 2'd0, 8'h00, 1'b0, 1'b1);

    // ALUout loop-back into an operand register uses the pre-edge result.
    InsSel = 2'd1; wr(4'd1, 3'd3); rd("loopback", 4'd1, 8'hFF);
    alu("loopback_alu", 2'd1, 8'hFF, 1'b0, 1'b0);

    // we low: nothing changes.
    InA = 8'hEE; RegAdd = 4'd3; InMuxAdd = 3'd0; step();
    rd("we_low_hold", 4'd3, 8'h05);
    check("we_low_result", Result, 8'h00);

    // Same-address read during write.
    InA = 8'h11; wr(4'd7, 3'd0);
    OutMuxAdd = 4'd7; InA = 8'hAA; we = 1'b1; RegAdd = 4'd7; InMuxAdd = 3'd0;
    #1;
    check("rw_old", RegOut, 8'h11);
    step();
    we = 1'b0;
    check("rw_new", RegOut, 8'hAA);

    // Back-to-back R0 writes.
    InA = 8'h01; wr(4'd0, 3'd0);
    check("b2b_valid1", ResultValid, 1'b1);
    check("b2b_result1", Result, 8'h01);
    InA = 8'h02; wr(4'd0, 3'd0);
    check("b2b_valid2", ResultValid, 1'b1);
    check("b2b_result2", Result, 8'h02);
    step();
    check("b2b_valid3", ResultValid, 1'b0);
    check("b2b_hold", Result, 8'h02);

    // Reset during a write loses the write.
    InA = 8'h33; wr(4'd6, 3'd0);
    reset = 1'b1; we = 1'b1; RegAdd = 4'd6; InMuxAdd = 3'd0; InA = 8'h99;
    step();
    reset = 1'b0; we = 1'b0;
    rd("midreset_r6", 4'd6, 8'h00);
    rd("midreset_r7", 4'd7, 8'h00);
    check("midreset_result", Result, 8'h00);

    // Multiply sequences.
    multiply(8'd5, 8'd3, 8'd15);
    multiply(8'd5, 8'd0, 8'd0);
    multiply(8'd0, 8'd3, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
